// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-input valid/ready stream multiplexer with a registered output stage.
// The grant comes either from an external select (MODE 0) or from a round-robin
// pointer that remembers the last channel served (MODE 1).
module mux_nx1_stream #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  logic             load_en;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  cand;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] grant_data;

  // The output register can accept a word when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Choose at most one channel: the selected one in MODE 0, or the first valid
  // channel after the last one served in MODE 1. An out-of-range sel matches nothing.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = SELW'((int'(rr_ptr) + k) % N);
        for (int i = 0; i < N; i++) begin
          if (!grant_any && cand == SELW'(i) && in_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
    end
  end

  // Expand the granted index into a one-hot vector and pick that channel's data.
  always_comb begin
    grant      = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_any && grant_idx == SELW'(i)) begin
        grant[i]   = 1'b1;
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is only offered while the output register can take the word.
  assign in_ready = {N{load_en}} & grant;

  // Output register and round-robin pointer; the pointer moves only on a transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else if (load_en) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant_idx;
        if (MODE != 0) begin
          rr_ptr <= grant_idx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: one instance per select mode, scoreboard of expected words.
`timescale 1ns/1ps
module tb_mux_nx1_stream;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 2;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SELW-1:0]  s;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic [SELW-1:0]    s_sel, r_sel;
  logic [N-1:0]       s_valid, r_valid, s_ready, r_ready;
  logic [N*WIDTH-1:0] s_data, r_data;
  logic               s_ovalid, r_ovalid, s_ordy, r_ordy;
  logic [WIDTH-1:0]   s_odata, r_odata;
  logic [SELW-1:0]    s_osrc, r_osrc;

  int checks   = 0;
  int failures = 0;

  exp_t q_s[$];
  exp_t q_r[$];

  logic             m_s_valid, m_r_valid;
  logic [WIDTH-1:0] m_s_data, m_r_data;
  logic [SELW-1:0]  m_s_src, m_r_src;
  int               m_r_ptr;

  always #5 clk = ~clk;

  mux_nx1_stream #(.N(N), .WIDTH(WIDTH), .MODE(0)) u_sel (
    .clk(clk), .rstn(rstn), .sel(s_sel), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .out_valid(s_ovalid), .out_data(s_odata), .out_src(s_osrc),
    .out_ready(s_ordy)
  );

  mux_nx1_stream #(.N(N), .WIDTH(WIDTH), .MODE(1)) u_rr (
    .clk(clk), .rstn(rstn), .sel(r_sel), .in_valid(r_valid), .in_data(r_data),
    .in_ready(r_ready), .out_valid(r_ovalid), .out_data(r_odata), .out_src(r_osrc),
    .out_ready(r_ordy)
  );

  function automatic int sel_pick(input logic [SELW-1:0] sl, input logic [N-1:0] v);
    if (v[sl]) return int'(sl);
    return -1;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_sel = '0; s_valid = '0; s_data = '0; s_ordy = 1'b0;
    r_sel = '0; r_valid = '0; r_data = '0; r_ordy = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_ovalid !== 1'b0 || s_odata !== '0 || s_osrc !== '0) begin
      failures++;
      $display("FAIL reset_sel: got v=%b d=%h s=%0d want v=0 d=00 s=0", s_ovalid, s_odata, s_osrc);
    end
    checks++;
    if (r_ovalid !== 1'b0 || r_odata !== '0 || r_osrc !== '0 || r_ready !== '0) begin
      failures++;
      $display("FAIL reset_rr: got v=%b d=%h s=%0d rdy=%b want v=0 d=00 s=0 rdy=0000",
               r_ovalid, r_odata, r_osrc, r_ready);
    end
    rstn = 1'b1;
    m_s_valid = 1'b0; m_s_data = '0; m_s_src = '0;
    m_r_valid = 1'b0; m_r_data = '0; m_r_src = '0; m_r_ptr = N - 1;
    tick();
  endtask

  task automatic test_mode0_stream();
    logic [SELW-1:0] t_sel [20];
    logic [N-1:0]    t_val [20];
    logic            t_rdy [20];
    int              pick;
    logic            le;
    logic [N-1:0]    er;
    exp_t            e;
    bit              pushed;
    // directed select, invalid select, load + 5-cycle stall + reload, then random
    t_sel[0] = 2; t_val[0] = 4'b0100; t_rdy[0] = 1'b1;
    t_sel[1] = 1; t_val[1] = 4'b1101; t_rdy[1] = 1'b1;
    t_sel[2] = 0; t_val[2] = 4'b0001; t_rdy[2] = 1'b1;
    for (int i = 3; i < 8; i++) begin
      t_sel[i] = SELW'($urandom_range(0, N - 1));
      t_val[i] = 4'b1111 ^ N'(i);
      t_rdy[i] = 1'b0;
    end
    t_sel[8] = 3; t_val[8] = 4'b1000; t_rdy[8] = 1'b1;
    for (int i = 9; i < 20; i++) begin
      t_sel[i] = SELW'($urandom_range(0, N - 1));
      t_val[i] = N'($urandom);
      t_rdy[i] = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20; i++) begin
      s_sel = t_sel[i]; s_valid = t_val[i]; s_ordy = t_rdy[i];
      for (int c = 0; c < N; c++) s_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      if (i == 0) s_data[2*WIDTH +: WIDTH] = 8'hA5;
      if (i == 2) s_data[0 +: WIDTH] = 8'h3C;
      if (i == 8) s_data[3*WIDTH +: WIDTH] = 8'h7E;
      #1;
      le   = !m_s_valid || s_ordy;
      pick = sel_pick(s_sel, s_valid);
      er   = (le && pick >= 0) ? N'(1 << pick) : '0;
      checks++;
      if (s_ready !== er) begin
        failures++;
        $display("FAIL sel_in_ready step %0d: got %b want %b", i, s_ready, er);
      end
      pushed = 0;
      if (le && pick >= 0) begin
        e.d = s_data[pick*WIDTH +: WIDTH];
        e.s = SELW'(pick);
        q_s.push_back(e);
        pushed = 1;
        m_s_valid = 1'b1; m_s_data = e.d; m_s_src = e.s;
      end else if (le) begin
        m_s_valid = 1'b0;
      end
      tick();
      if (pushed) begin
        e = q_s.pop_front();
        checks++;
        if (s_ovalid !== 1'b1 || s_odata !== e.d || s_osrc !== e.s) begin
          failures++;
          $display("FAIL sel_out_word step %0d: got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                   i, s_ovalid, s_odata, s_osrc, e.d, e.s);
        end
      end else begin
        checks++;
        if (s_ovalid !== m_s_valid || s_odata !== m_s_data || s_osrc !== m_s_src) begin
          failures++;
          $display("FAIL sel_out_hold step %0d: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                   i, s_ovalid, s_odata, s_osrc, m_s_valid, m_s_data, m_s_src);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    // Put a word into each output register, then reset between clock edges.
    s_sel = 0; s_valid = 4'b0001; s_ordy = 1'b1; s_data[0 +: WIDTH] = 8'h5A;
    r_valid = 4'b0100; r_ordy = 1'b1; r_data[2*WIDTH +: WIDTH] = 8'hC3;
    tick();
    s_valid = '0; r_valid = '0; s_ordy = 1'b0; r_ordy = 1'b0;
    checks++;
    if (s_ovalid !== 1'b1 || s_odata !== 8'h5A || r_ovalid !== 1'b1 || r_odata !== 8'hC3 ||
        r_osrc !== 2'd2) begin
      failures++;
      $display("FAIL preload: got sv=%b sd=%h rv=%b rd=%h rs=%0d want sv=1 sd=5a rv=1 rd=c3 rs=2",
               s_ovalid, s_odata, r_ovalid, r_odata, r_osrc);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (s_ovalid !== 1'b0 || s_odata !== '0 || s_osrc !== '0) begin
      failures++;
      $display("FAIL async_reset_sel: got v=%b d=%h s=%0d want v=0 d=00 s=0", s_ovalid, s_odata, s_osrc);
    end
    checks++;
    if (r_ovalid !== 1'b0 || r_odata !== '0 || r_osrc !== '0) begin
      failures++;
      $display("FAIL async_reset_rr: got v=%b d=%h s=%0d want v=0 d=00 s=0", r_ovalid, r_odata, r_osrc);
    end
    tick();
    rstn = 1'b1;
    q_s.delete(); q_r.delete();
    m_s_valid = 1'b0; m_s_data = '0; m_s_src = '0;
    m_r_valid = 1'b0; m_r_data = '0; m_r_src = '0; m_r_ptr = N - 1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] t_val [24];
    logic         t_rdy [24];
    int           pick;
    logic         le;
    logic [N-1:0] er;
    exp_t         e;
    bit           pushed;
    // fairness (expect 0,1,2,3,0,1), then skip/wrap with stalls and an idle cycle
    for (int i = 0; i < 6; i++) begin t_val[i] = 4'b1111; t_rdy[i] = 1'b1; end
    t_val[6]  = 4'b1000; t_rdy[6]  = 1'b1;
    t_val[7]  = 4'b1001; t_rdy[7]  = 1'b1;
    t_val[8]  = 4'b1001; t_rdy[8]  = 1'b0;
    t_val[9]  = 4'b1001; t_rdy[9]  = 1'b0;
    t_val[10] = 4'b1001; t_rdy[10] = 1'b1;
    t_val[11] = 4'b0000; t_rdy[11] = 1'b1;
    t_val[12] = 4'b1001; t_rdy[12] = 1'b1;
    t_val[13] = 4'b1001; t_rdy[13] = 1'b0;
    t_val[14] = 4'b1001; t_rdy[14] = 1'b1;
    t_val[15] = 4'b1001; t_rdy[15] = 1'b1;
    for (int i = 16; i < 24; i++) begin
      t_val[i] = N'($urandom);
      t_rdy[i] = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 24; i++) begin
      r_sel = SELW'($urandom_range(0, N - 1));
      r_valid = t_val[i]; r_ordy = t_rdy[i];
      for (int c = 0; c < N; c++) r_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      #1;
      le   = !m_r_valid || r_ordy;
      pick = rr_pick(m_r_ptr, r_valid);
      er   = (le && pick >= 0) ? N'(1 << pick) : '0;
      checks++;
      if (r_ready !== er) begin
        failures++;
        $display("FAIL rr_in_ready step %0d: got %b want %b", i, r_ready, er);
      end
      pushed = 0;
      if (le && pick >= 0) begin
        e.d = r_data[pick*WIDTH +: WIDTH];
        e.s = SELW'(pick);
        q_r.push_back(e);
        pushed = 1;
        m_r_ptr = pick;
        m_r_valid = 1'b1; m_r_data = e.d; m_r_src = e.s;
      end else if (le) begin
        m_r_valid = 1'b0;
      end
      tick();
      if (pushed) begin
        e = q_r.pop_front();
        checks++;
        if (r_ovalid !== 1'b1 || r_odata !== e.d || r_osrc !== e.s) begin
          failures++;
          $display("FAIL rr_out_word step %0d: got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                   i, r_ovalid, r_odata, r_osrc, e.d, e.s);
        end
      end else begin
        checks++;
        if (r_ovalid !== m_r_valid || r_odata !== m_r_data || r_osrc !== m_r_src) begin
          failures++;
          $display("FAIL rr_out_hold step %0d: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                   i, r_ovalid, r_odata, r_osrc, m_r_valid, m_r_data, m_r_src);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_stream();
    test_reset_midstream();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
